// File: rtl/banner_renderer.sv
// Banner overlay: shows a scaled ROM image starting on a frame boundary and
// removes it on a frame boundary. Optional blinking via BANNER_BLINK_EN.
module banner_renderer #(
  parameter int SCALE_SHIFT  = 2,
  parameter int SRC_W        = 160,
  parameter int SRC_H        = 120,
  parameter int NUM_IMG      = 2,
  parameter int ADDR_W       = 16,
  parameter int HOLD_FRAMES  = 180,
  parameter int BLINK_FRAMES = 30,
  localparam int SEL_W       = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              start,
  input  logic              stop,
  input  logic [SEL_W-1:0]  img_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [11:0]       pix_out,
  output logic              pix_valid,
  output logic              busy
);

  localparam int FC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [FC_W-1:0]   HOLD_L   = FC_W'(HOLD_FRAMES);
  localparam logic [9:0]        SRC_W_L  = 10'(SRC_W);
  localparam logic [9:0]        SRC_H_L  = 10'(SRC_H);
  localparam logic [ADDR_W-1:0] IMG_SZ   = ADDR_W'(SRC_W * SRC_H);
  localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(SRC_W);
  localparam logic [SEL_W-1:0]  IMG_LAST = SEL_W'(NUM_IMG - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              fb;
  logic [SEL_W-1:0]  img, img_clamped;
  logic [FC_W-1:0]   frame_cnt, frame_inc;
  logic              hold_hit;
  logic              en0;

`ifdef BANNER_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);
  logic [BC_W-1:0] blink_cnt;
  logic            vis;
`endif

  assign fb          = (x == '0) && (y == '0);
  assign img_clamped = (32'(img_sel) >= 32'(NUM_IMG)) ? IMG_LAST : img_sel;
  assign frame_inc   = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
  assign hold_hit    = (HOLD_FRAMES != 0) && (frame_inc >= HOLD_L);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start && !stop) state_nxt = ARMED;
      ARMED: if (fb) state_nxt = SHOW;
      SHOW: begin
        if (stop)                state_nxt = DRAIN;
        else if (start)          state_nxt = ARMED;
        else if (fb && hold_hit) state_nxt = DRAIN;
      end
      DRAIN: if (fb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    en0  = 1'b0;
    unique case (state)
`ifdef BANNER_BLINK_EN
      SHOW:    en0 = vis;
`else
      SHOW:    en0 = 1'b1;
`endif
      DRAIN:   en0 = 1'b1;
      default: en0 = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      img       <= '0;
      frame_cnt <= '0;
`ifdef BANNER_BLINK_EN
      blink_cnt <= '0;
      vis       <= 1'b1;
`endif
    end else begin
      if (start && !stop && (state == IDLE || state == SHOW))
        img <= img_clamped;
      if (state == ARMED && fb) begin
        frame_cnt <= '0;
`ifdef BANNER_BLINK_EN
        blink_cnt <= '0;
        vis       <= 1'b1;
`endif
      end else if (state == SHOW && fb) begin
        frame_cnt <= frame_inc;
`ifdef BANNER_BLINK_EN
        if (blink_cnt == BC_LAST) begin
          blink_cnt <= '0;
          vis       <= ~vis;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
`endif
      end
    end
  end

  // Stage 0: texel coordinates and address, row widened so SRC_H up to 1023 works
  logic [9:0]        col, row;
  logic              in_area;
  logic [ADDR_W-1:0] addr0;
  logic              area1, en1, area2, en2;

  assign col     = x >> SCALE_SHIFT;
  assign row     = {1'b0, y} >> SCALE_SHIFT;
  assign in_area = (col < SRC_W_L) && (row < SRC_H_L);
  assign addr0   = ADDR_W'(img) * IMG_SZ + ADDR_W'(row) * ROW_SZ + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr  <= '0;
      area1     <= 1'b0;
      en1       <= 1'b0;
      area2     <= 1'b0;
      en2       <= 1'b0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      rom_addr <= in_area ? addr0 : '0;
      area1    <= in_area;
      en1      <= en0;
      area2    <= area1;
      en2      <= en1;
      if (area2 && en2) begin
        pix_out   <= {rom_data[7:5], 1'b0, rom_data[4:2], 1'b0, rom_data[1:0], 2'b00};
        pix_valid <= 1'b1;
      end else begin
        pix_out   <= '0;
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_banner_renderer.sv
// Bench for banner_renderer: two instances (SCALE_SHIFT 2 and 1) checked every
// cycle against a frame-level model, plus directed literal checks.
module tb_banner_renderer;

  localparam int HOLD  = 2;
  localparam int BLINK = 1;
  localparam int NIMG  = 2;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic [0:0]  img_sel = '0;
  logic [15:0] rom_addr0, rom_addr1;
  logic [7:0]  rom_data0 = '0, rom_data1 = '0;
  logic [11:0] pix0, pix1;
  logic        v0, v1, busy0, busy1;
  bit          rom_force = 1'b0, chk_en = 1'b0;
  int          compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  banner_renderer #(.SCALE_SHIFT(2), .SRC_W(160), .SRC_H(120), .NUM_IMG(NIMG),
    .ADDR_W(16), .HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)) u_dut0 (
    .clk(clk), .reset(reset), .x(x), .y(y), .start(start), .stop(stop),
    .img_sel(img_sel), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .pix_out(pix0), .pix_valid(v0), .busy(busy0));

  banner_renderer #(.SCALE_SHIFT(1), .SRC_W(160), .SRC_H(120), .NUM_IMG(NIMG),
    .ADDR_W(16), .HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)) u_dut1 (
    .clk(clk), .reset(reset), .x(x), .y(y), .start(start), .stop(stop),
    .img_sel(img_sel), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .pix_out(pix1), .pix_valid(v1), .busy(busy1));

  function automatic logic [7:0] rom_fn(input logic [15:0] a, input bit f);
    return f ? 8'hFF : (a[7:0] ^ a[15:8] ^ 8'h5A);
  endfunction

  function automatic logic [11:0] rgb444(input logic [7:0] d);
    return {d[7:5], 1'b0, d[4:2], 1'b0, d[1:0], 2'b00};
  endfunction

  always @(posedge clk) begin
    rom_data0 <= rom_fn(rom_addr0, rom_force);
    rom_data1 <= rom_fn(rom_addr1, rom_force);
  end

  // Model: mode 0 idle, 1 armed, 2 show, 3 drain; [k][s] = instance k, stage s
  int          m_mode = 0, m_frames = 0, m_bc = 0, m_img = 0;
  bit          m_vis = 1'b1;
  logic [15:0] m_a [2][3];
  logic [7:0]  m_d [2][3];
  bit          m_v [2][3];

  always @(posedge clk) begin : model
    int  col, row, sh;
    bit  area, en, fb;
    if (reset) begin
      m_mode = 0; m_frames = 0; m_bc = 0; m_img = 0; m_vis = 1'b1;
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < 3; s++) begin
          m_a[k][s] = '0; m_d[k][s] = '0; m_v[k][s] = 1'b0;
        end
    end else begin
      en = (m_mode == 3) || (m_mode == 2 && m_vis);
      fb = (x == 0) && (y == 0);
      for (int k = 0; k < 2; k++) begin
        m_v[k][2] = m_v[k][1];
        m_d[k][2] = m_d[k][1];
        m_v[k][1] = m_v[k][0];
        m_d[k][1] = rom_fn(m_a[k][0], rom_force);
        sh   = (k == 0) ? 2 : 1;
        col  = int'(x) >> sh;
        row  = int'(y) >> sh;
        area = (col < 160) && (row < 120);
        m_a[k][0] = area ? 16'((m_img * 19200 + row * 160 + col) % 65536) : 16'h0;
        m_v[k][0] = area && en;
      end
      case (m_mode)
        0: if (start && !stop) begin
             m_img  = (int'(img_sel) > NIMG - 1) ? NIMG - 1 : int'(img_sel);
             m_mode = 1;
           end
        1: if (fb) begin
             m_mode = 2; m_frames = 0; m_bc = 0; m_vis = 1'b1;
           end
        2: if (stop) m_mode = 3;
           else if (start) begin
             m_img  = (int'(img_sel) > NIMG - 1) ? NIMG - 1 : int'(img_sel);
             m_mode = 1;
           end else if (fb) begin
             m_frames++;
             if (HOLD != 0 && m_frames >= HOLD) m_mode = 3;
`ifdef BANNER_BLINK_EN
             m_bc++;
             if (m_bc == BLINK) begin
               m_bc  = 0;
               m_vis = !m_vis;
             end
`endif
           end
        3: if (fb) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rom_addr0", rom_addr0, m_a[0][0]);
      check("pix_out0",  pix0, m_v[0][2] ? rgb444(m_d[0][2]) : 12'h000);
      check("pix_valid0", v0, m_v[0][2]);
      check("busy0", busy0, m_mode != 0);
      check("rom_addr1", rom_addr1, m_a[1][0]);
      check("pix_out1",  pix1, m_v[1][2] ? rgb444(m_d[1][2]) : 12'h000);
      check("pix_valid1", v1, m_v[1][2]);
      check("busy1", busy1, m_mode != 0);
    end
  end

  task automatic drive(input int xx, input int yy);
    x = 10'(xx);
    y = 9'(yy);
    @(negedge clk);
  endtask

  initial begin
    x = 10'd5; y = 9'd5; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_pix", pix0, 12'h000);
    check("rst_valid", v0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_addr", rom_addr0, 16'd0);
    reset = 1'b0;

    drive(639, 479);
    check("corner_addr0", rom_addr0, 16'd19199);
    check("corner_addr1", rom_addr1, 16'd0);
    drive(400, 10);
    check("wide_addr1", rom_addr1, 16'd0);

    // start mid-frame with image 1
    start = 1'b1; img_sel = 1'b1;
    drive(100, 50);
    start = 1'b0;
    check("armed_busy", busy0, 1'b1);
    drive(101, 50);
    drive(102, 50);
    check("armed_valid", v0, 1'b0);
    drive(0, 0);
    rom_force = 1'b1;
    drive(8, 4);
    check("img1_addr", rom_addr0, 16'd19362);
    drive(9, 4);
    drive(10, 4);
    check("img1_pix", pix0, 12'hEEC);
    check("img1_valid", v0, 1'b1);
    rom_force = 1'b0;
    for (int i = 1; i < 21; i++) drive(i * 30, i * 4);
    drive(400, 10);
    drive(401, 10);
    drive(402, 10);
    check("wide_valid0", v0, 1'b1);
    check("wide_valid1", v1, 1'b0);

    // hold of 2 frames, then one drain frame
    drive(0, 0);
    for (int i = 0; i < 6; i++) drive(i * 7 + 1, 3);
    drive(0, 0);
    check("drain_busy", busy0, 1'b1);
    for (int i = 0; i < 4; i++) drive(i + 20, 6);
    check("drain_valid", v0, 1'b1);
    drive(0, 0);
    check("idle_busy", busy0, 1'b0);
    for (int i = 0; i < 4; i++) drive(i + 20, 6);
    check("idle_valid", v0, 1'b0);

    // start and stop together in SHOW: stop wins
    start = 1'b1; img_sel = 1'b0;
    drive(3, 3);
    start = 1'b0;
    drive(0, 0);
    for (int i = 0; i < 5; i++) drive(i * 50 + 4, 40);
    start = 1'b1; stop = 1'b1;
    drive(20, 20);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) drive(i + 60, 30);
    drive(0, 0);
    check("stopwin_busy", busy0, 1'b0);

    // relatch image from SHOW
    start = 1'b1; img_sel = 1'b1;
    drive(7, 7);
    start = 1'b0;
    drive(0, 0);
    for (int i = 0; i < 5; i++) drive(i * 33 + 2, 100);
    start = 1'b1; img_sel = 1'b0;
    drive(5, 5);
    start = 1'b0;
    for (int i = 0; i < 4; i++) drive(i * 10 + 1, 200);
    check("relatch_busy", busy0, 1'b1);
    drive(0, 0);
    for (int i = 0; i < 5; i++) drive(i * 90 + 3, 300);

    // reset in the middle of SHOW flushes the pipeline
    reset = 1'b1;
    drive(20, 20);
    check("midrst_valid", v0, 1'b0);
    check("midrst_pix", pix0, 12'h000);
    check("midrst_busy", busy0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) drive(i + 1, 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
